// File: rtl/serial_addsub_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_addsub_fsm: bit-serial add/subtract, LSB first   Rev 1.0
// ------------------------------------------------------------------
module serial_addsub_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;

  assign sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign last_bit   = (cnt == LAST);

  // Sum bits enter from the MSB side so the result is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = sum_bit;
    end else begin : g_res_wn
      assign res_next = {sum_bit, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      s      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      sh_a  <= a;
      sh_b  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      carry  <= carry_next;
      res_sh <= res_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        s   <= res_next;
        co  <= carry_next;
        ovf <= carry ^ carry_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_fsm.sv
`default_nettype none
// Scoreboard bench for serial_addsub_fsm at WIDTH=8 and WIDTH=1.
module tb_serial_addsub_fsm;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] s;
  logic       co, ovf;

  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] s1;
  logic       co1, ovf1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  logic [7:0] prev_s;

  serial_addsub_fsm #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  serial_addsub_fsm #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("w8_s", 32'(s), e8.s);
        chk("w8_co", 32'(co), 32'(e8.co));
        chk("w8_ovf", 32'(ovf), 32'(e8.ovf));
        chk("w8_done_cycle", 32'(cyc), 32'(e8.cyc + 8));
        chk("w8_busy_in_done", 32'(busy), 32'd1);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("w1_s", 32'(s1), e1.s);
        chk("w1_co", 32'(co1), 32'(e1.co));
        chk("w1_ovf", 32'(ovf1), 32'(e1.ovf));
        chk("w1_done_cycle", 32'(cyc), 32'(e1.cyc + 1));
      end
    end
  end

  task automatic issue8(input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] es, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    start = 1'b1; sub = sb; a = aa; b = bb;
    @(posedge clk);
    #1;
    e.s = 32'(es); e.co = eco; e.ovf = eovf; e.cyc = cyc;
    q8.push_back(e);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("w8_busy_in_run", 32'(busy), 32'd1);
    chk("w8_s_hold_in_run", 32'(s), 32'(prev_s));
    repeat (6) @(negedge clk);
    prev_s = es;
  endtask

  task automatic issue1(input logic sb, input logic aa, input logic bb,
                        input logic es, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; sub1 = sb; a1 = aa; b1 = bb;
    @(posedge clk);
    #1;
    e.s = 32'(es); e.co = eco; e.ovf = eovf; e.cyc = cyc;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0; a1 = ~aa; b1 = ~bb; sub1 = ~sb;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    reset = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    prev_s = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_w1_busy", 32'(busy1), 32'd0);
    reset = 1'b1;

    issue8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    issue8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    issue8(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    issue8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    issue8(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    issue8(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    issue8(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    issue8(1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1);
    issue8(1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    issue8(1'b1, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0);

    // start held high with operands changing every cycle: accepted at offsets 0, 10, 20.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'd0; b = 8'd0;
    @(posedge clk);
    #1;
    n0 = cyc;
    q8.push_back('{32'h00, 1'b0, 1'b0, n0});
    q8.push_back('{32'h1E, 1'b0, 1'b0, n0 + 10});
    q8.push_back('{32'h3C, 1'b0, 1'b0, n0 + 20});
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      a = 8'(i); b = 8'(2 * i);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-RUN: no done must follow.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h55; b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_co", 32'(co), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    prev_s = '0;
    repeat (12) @(negedge clk);
    issue8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    issue1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    issue1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 100 && (q8.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    while (q8.size() != 0) begin
      e8 = q8.pop_front();
      chk("w8_done_timeout", 32'd0, 32'd1);
    end
    while (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("w1_done_timeout", 32'd0, 32'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub_fsm.md
SERIAL_ADDSUB_FSM -- requirements
Module: serial_addsub_fsm

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  mode; 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: s  output  WIDTH  result, registered.
REQ-011 SHALL have port: co  output  1  carry out; for sub, 1 = no borrow.
REQ-012 SHALL have port: ovf  output  1  two's-complement signed overflow.

Function
REQ-013 SHALL implement a three-state FSM (IDLE, RUN, DONE) with binary-encoded state register and separate next-state logic.
REQ-014 IDLE: start=1 at an edge SHALL latch a into shift reg A and b XOR {WIDTH{sub}} into shift reg B, set carry register to sub, clear bit counter, and go to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each edge SHALL process one bit, LSB first: sum bit = A[0]^B[0]^c, c <= majority(A[0],B[0],c); shift A, B right; shift sum bit into result shift register from MSB side.
REQ-016 RUN SHALL last exactly WIDTH edges; at the WIDTH-th RUN edge the FSM SHALL go to DONE and load s, co, ovf in the same edge.
REQ-017 co SHALL equal the final carry; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally at the next edge.
REQ-019 Latency: start sampled at edge 0 -> s/co/ovf valid and done=1 in the cycle after edge WIDTH.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored; no queuing; a, b, sub changes during RUN SHALL NOT affect the result.
REQ-021 s, co, ovf SHALL hold the last result until the next DONE entry; they SHALL NOT change during RUN.
REQ-022 start asserted in the IDLE cycle directly after DONE SHALL be accepted (back-to-back period = WIDTH+2 cycles).
REQ-023 WIDTH=1 SHALL work: one RUN edge; ovf = carry-in XOR carry-out of bit 0.
REQ-024 Bit counter width SHALL be sufficient to count to WIDTH without wrap; no unreachable state SHALL lock up (illegal state encoding -> IDLE).

Reset
REQ-025 reset=0 SHALL, asynchronously: state=IDLE, busy=0, done=0, s=0, co=0, ovf=0, carry/counter/shift registers cleared.
REQ-026 reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; first start after reset release SHALL behave as from power-up.

Verification
REQ-027 WIDTH=8, sub=0, a=0xFF, b=0x01 -> done 8 cycles after start edge, s=0x00, co=1, ovf=0.
REQ-028 WIDTH=8, sub=0, a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1.
REQ-029 WIDTH=8, sub=1, a=0x05, b=0x07 -> s=0xFE, co=0, ovf=0; sub=1, a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.
REQ-030 start pulsed every cycle with changing a/b during RUN -> only first operands used; done spaced exactly 10 cycles apart (WIDTH+2) with start held high.
REQ-031 reset pulsed low at RUN bit 4 -> outputs 0 immediately, no done; next op 0x12+0x34 -> s=0x46, co=0, ovf=0.
REQ-032 Random regression, WIDTH in {1,8,16,32}, all modes -> s, co, ovf match reference arithmetic model for every done.
